// File: rtl/rcu_seq_pkg.sv
// Shared types and constants for the RCU reset/clock-enable sequencer.
// Holds the FSM state encoding, the APB word map and the register reset values.
package rcu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_CH_EN     = 3'd2,
        ST_CH_RST    = 3'd3,
        ST_RUN       = 3'd4,
        ST_REASSERT  = 3'd5,
        ST_ERR       = 3'd6
    } state_e;

    localparam logic [3:0] REG_CTRL = 4'd0;
    localparam logic [3:0] REG_CHEN = 4'd1;
    localparam logic [3:0] REG_DLY  = 4'd2;
    localparam logic [3:0] REG_TMO  = 4'd3;
    localparam logic [3:0] REG_STAT = 4'd4;

    localparam logic [15:0] CHEN_RST = 16'hFFFF;
    localparam int unsigned DLY_RST  = 8;

endpackage

// File: rtl/rcu_seq_cnt.sv
// Gap/timeout counter: load clears it, expires at max(lim,1)-1 and holds there.
// Latency: limit captured at load; exp_o is combinational from the count.
// Backpressure: none.
module rcu_seq_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] lim_i,
    output logic         exp_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] end_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            end_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
            // A zero limit behaves like one so every timed step lasts at least a cycle.
            end_q <= (lim_i == '0) ? '0 : W'(lim_i - 1'b1);
        end else if (cnt_q != end_q) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign exp_o = (cnt_q == end_q);

endmodule

// File: rtl/apb4_rcu_seq.sv
// RCU sequencer: releases NUM_CH domains one by one after PLL lock, re-asserts on fault.
// Latency: APB zero wait states; START at T leaves IDLE at T+1; each channel costs 2*DLY.
// Backpressure: none, pready_o tied high.
module apb4_rcu_seq #(
    parameter int NUM_CH    = 6,
    parameter int DLY_WIDTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       paddr_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    input  logic              pll_lock_i,
    input  logic              wdt_req_i,
    output logic [NUM_CH-1:0] clk_en_o,
    output logic [NUM_CH-1:0] rst_o,
    output logic              irq_o
);
    import rcu_seq_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(NUM_CH - 1);

    state_e                state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [NUM_CH-1:0]     en_q, en_d, rst_q, rst_d, chen_q, sel_q, sel_d;
    logic [DLY_WIDTH-1:0]  dly_q, tmo_q, cnt_lim;
    logic                  bypass_q, auto_en_q, auto_q, auto_d;
    logic                  done_q, terr_q, irq_q, irq_d;
    logic                  done_set, done_clr, terr_set, terr_clr;
    logic                  cnt_load, cnt_exp;
    logic                  acc_wr, acc_rd, start_p, swrst_p;
    logic                  lock_lost, reassert, busy;
    logic [3:0]            widx;
    logic [31:0]           rdata;
    logic                  unused_apb;

    assign widx     = paddr_i[5:2];
    assign acc_wr   = psel_i & penable_i & pwrite_i;
    assign acc_rd   = psel_i & penable_i & ~pwrite_i;
    assign swrst_p  = acc_wr && (widx == REG_CTRL) && pwdata_i[1];
    assign start_p  = acc_wr && (widx == REG_CTRL) && pwdata_i[0] && !pwdata_i[1];
    assign terr_clr = acc_wr && (widx == REG_STAT) && pwdata_i[2];

    assign unused_apb = ^{paddr_i[31:6], paddr_i[1:0], pwdata_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bypass_q  <= 1'b0;
            auto_en_q <= 1'b0;
            chen_q    <= CHEN_RST[NUM_CH-1:0];
            dly_q     <= DLY_WIDTH'(DLY_RST);
            tmo_q     <= '1;
        end else if (acc_wr) begin
            case (widx)
                REG_CTRL: begin
                    bypass_q  <= pwdata_i[2];
                    auto_en_q <= pwdata_i[3];
                end
                REG_CHEN: chen_q <= pwdata_i[NUM_CH-1:0];
                REG_DLY:  dly_q  <= pwdata_i[DLY_WIDTH-1:0];
                REG_TMO:  tmo_q  <= pwdata_i[DLY_WIDTH-1:0];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            terr_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (terr_set)      terr_q <= 1'b1;
            else if (terr_clr) terr_q <= 1'b0;
            if (done_set)      done_q <= 1'b1;
            else if (done_clr) done_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            en_q    <= '0;
            rst_q   <= '1;
            irq_q   <= 1'b0;
            auto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            rst_q   <= rst_d;
            irq_q   <= irq_d;
            auto_q  <= auto_d;
        end
    end

    assign sel_q     = NUM_CH'(1) << idx_q;
    assign lock_lost = !pll_lock_i && !bypass_q;
    assign reassert  = swrst_p || wdt_req_i || lock_lost;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        en_d     = en_q;
        rst_d    = rst_q;
        irq_d    = 1'b0;
        auto_d   = auto_q;
        done_set = 1'b0;
        done_clr = 1'b0;
        terr_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (swrst_p) begin
                    auto_d = 1'b0;
                end else if (start_p || auto_q) begin
                    auto_d  = 1'b0;
                    idx_d   = '0;
                    state_d = (bypass_q || pll_lock_i) ? ST_CH_EN : ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is expected to be low here, so only explicit requests re-assert.
                if (swrst_p || wdt_req_i) begin
                    state_d = ST_REASSERT;
                end else if (pll_lock_i || bypass_q) begin
                    state_d = ST_CH_EN;
                    idx_d   = '0;
                end else if (cnt_exp) begin
                    state_d  = ST_ERR;
                    terr_set = 1'b1;
                    irq_d    = 1'b1;
                end
            end
            ST_CH_EN: begin
                if (reassert) begin
                    state_d = ST_REASSERT;
                end else if (!(|(en_q & sel_q)) || cnt_exp) begin
                    // A disabled channel never got its enable set, so it advances at once.
                    if (|(en_q & sel_q)) begin
                        state_d = ST_CH_RST;
                        rst_d   = rst_q & ~sel_q;
                    end else if (idx_q == LAST_IDX) begin
                        state_d  = ST_RUN;
                        done_set = 1'b1;
                        irq_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_CH_RST: begin
                if (reassert) begin
                    state_d = ST_REASSERT;
                end else if (cnt_exp) begin
                    if (idx_q == LAST_IDX) begin
                        state_d  = ST_RUN;
                        done_set = 1'b1;
                        irq_d    = 1'b1;
                    end else begin
                        state_d = ST_CH_EN;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            ST_RUN: begin
                if (reassert) state_d = ST_REASSERT;
            end
            ST_REASSERT: begin
                if (cnt_exp) begin
                    state_d  = ST_IDLE;
                    idx_d    = '0;
                    en_d     = '0;
                    done_clr = 1'b1;
                    auto_d   = auto_en_q;
                end
            end
            ST_ERR: begin
                if (swrst_p) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Any state or channel change restarts the shared counter with the limit
        // that belongs to the step being entered.
        cnt_load = (state_d != state_q) || (idx_d != idx_q);
        sel_d    = NUM_CH'(1) << idx_d;
        cnt_lim  = (state_d == ST_WAIT_LOCK) ? tmo_q : dly_q;
        if (cnt_load && (state_d == ST_CH_EN))    en_d  = en_q | (chen_q & sel_d);
        if (cnt_load && (state_d == ST_REASSERT)) rst_d = '1;
    end

    rcu_seq_cnt #(
        .W(DLY_WIDTH)
    ) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load_i(cnt_load),
        .lim_i (cnt_lim),
        .exp_o (cnt_exp)
    );

    assign busy = (state_q == ST_WAIT_LOCK) || (state_q == ST_CH_EN) ||
                  (state_q == ST_CH_RST)    || (state_q == ST_REASSERT);

    always_comb begin
        rdata = '0;
        case (widx)
            REG_CTRL: rdata[3:2] = {auto_en_q, bypass_q};
            REG_CHEN: rdata[NUM_CH-1:0] = chen_q;
            REG_DLY:  rdata[DLY_WIDTH-1:0] = dly_q;
            REG_TMO:  rdata[DLY_WIDTH-1:0] = tmo_q;
            REG_STAT: begin
                rdata[0]    = busy;
                rdata[1]    = done_q;
                rdata[2]    = terr_q;
                rdata[6:4]  = state_q;
                rdata[11:8] = idx_q;
            end
            default: ;
        endcase
    end

    assign prdata_o  = acc_rd ? rdata : 32'd0;
    assign pready_o  = 1'b1;
    assign pslverr_o = 1'b0;
    assign clk_en_o  = en_q;
    assign rst_o     = rst_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_apb4_rcu_seq.sv
// Bench for apb4_rcu_seq with NUM_CH=4: expected output events are queued per cycle
// when stimulus is issued and compared on the falling edge of that cycle.
module tb_apb4_rcu_seq;
    localparam int NCH = 4;
    localparam int DW  = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [31:0]    paddr = '0, pwdata = '0, prdata;
    logic           psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic           pready, pslverr;
    logic           pll_lock = 1'b1, wdt_req = 1'b0;
    logic [NCH-1:0] clk_en, rst_v;
    logic           irq;

    apb4_rcu_seq #(.NUM_CH(NCH), .DLY_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
        .pslverr_o(pslverr), .pll_lock_i(pll_lock), .wdt_req_i(wdt_req),
        .clk_en_o(clk_en), .rst_o(rst_v), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        string       tag;
        int          kind;   // 0 clk_en, 1 rst, 2 irq
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_at(input int c, input string tag, input int kind, input logic [31:0] v);
        exp_t e;
        e.cyc = c; e.tag = tag; e.kind = kind; e.val = v;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        logic [31:0] o;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                check_eq({sb[i].tag, "_missed"}, 32'(cyc), 32'(sb[i].cyc));
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    0:       o = 32'(clk_en);
                    1:       o = 32'(rst_v);
                    default: o = {31'd0, irq};
                endcase
                check_eq(sb[i].tag, o, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() > 0) begin
            check_eq("sb_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Both APB tasks are entered and left 1 ns after a rising edge.
    task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
        paddr = {26'd0, a, 2'b00}; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [3:0] a, output logic [31:0] v);
        paddr = {26'd0, a, 2'b00}; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        #1 v = prdata;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int T, c;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_clk_en", 32'(clk_en), 32'h0);
        check_eq("rst_rst", 32'(rst_v), 32'hF);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        check_eq("rst_prdata", prdata, 32'd0);
        check_eq("rst_pready", {31'd0, pready}, 32'd1);
        check_eq("rst_pslverr", {31'd0, pslverr}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        paddr = 32'h4; psel = 1'b1; #1;
        check_eq("prdata_setup", prdata, 32'd0);
        psel = 1'b0;
        apb_rd(4'd0, v); check_eq("rd_ctrl", v, 32'h0);
        apb_rd(4'd1, v); check_eq("rd_chen", v, 32'hF);
        apb_rd(4'd2, v); check_eq("rd_dly", v, 32'd8);
        apb_rd(4'd3, v); check_eq("rd_tmo", v, 32'hFFFF);
        apb_rd(4'd4, v); check_eq("rd_stat", v, 32'h0);
        apb_rd(4'd7, v); check_eq("rd_unmapped", v, 32'h0);

        // A: bypass sequence, DLY=3, all channels
        apb_wr(4'd2, 32'd3);
        apb_wr(4'd0, 32'h4);
        T = cyc + 1;
        expect_at(T, "A_en_acc", 0, 32'h0);
        for (int k = 0; k < NCH; k++) begin
            c = T + 1 + 6 * k;
            if (k > 0) expect_at(c - 1, $sformatf("A_en_pre%0d", k), 0, 32'((1 << k) - 1));
            expect_at(c, $sformatf("A_en%0d", k), 0, 32'((1 << (k + 1)) - 1));
            expect_at(c + 2, $sformatf("A_rst_pre%0d", k), 1, 32'hF & ~32'((1 << k) - 1));
            expect_at(c + 3, $sformatf("A_rst%0d", k), 1, 32'hF & ~32'((1 << (k + 1)) - 1));
        end
        expect_at(T + 24, "A_irq_pre", 2, 32'd0);
        expect_at(T + 25, "A_irq", 2, 32'd1);
        expect_at(T + 26, "A_irq_post", 2, 32'd0);
        apb_wr(4'd0, 32'h5);
        drain(60);
        apb_rd(4'd4, v); check_eq("A_stat_run", v, 32'h342);

        // B: SWRST from RUN, then sparse CHEN with DLY=2
        apb_wr(4'd2, 32'd2);
        T = cyc + 1;
        expect_at(T + 1, "B_swrst_rst", 1, 32'hF);
        expect_at(T + 2, "B_swrst_en_hold", 0, 32'hF);
        expect_at(T + 3, "B_swrst_en_off", 0, 32'h0);
        apb_wr(4'd0, 32'h6);
        drain(20);
        apb_wr(4'd1, 32'h5);
        T = cyc + 1;
        expect_at(T + 1, "B_en0", 0, 32'h1);
        expect_at(T + 3, "B_rst0", 1, 32'hE);
        expect_at(T + 5, "B_skip1_en", 0, 32'h1);
        expect_at(T + 6, "B_en2", 0, 32'h5);
        expect_at(T + 8, "B_rst2", 1, 32'hA);
        expect_at(T + 10, "B_irq_pre", 2, 32'd0);
        expect_at(T + 11, "B_irq", 2, 32'd1);
        expect_at(T + 12, "B_final_en", 0, 32'h5);
        expect_at(T + 12, "B_final_rst", 1, 32'hA);
        apb_wr(4'd0, 32'h5);
        drain(40);

        // C: watchdog pulse in RUN with AUTO restart, DLY=4
        apb_wr(4'd2, 32'd4);
        apb_wr(4'd0, 32'hC);
        T = cyc;
        expect_at(T, "C_rst_before", 1, 32'hA);
        expect_at(T + 1, "C_rst_all", 1, 32'hF);
        expect_at(T + 4, "C_en_hold", 0, 32'h5);
        expect_at(T + 5, "C_en_off", 0, 32'h0);
        expect_at(T + 6, "C_auto_en0", 0, 32'h1);
        expect_at(T + 6, "C_auto_rst", 1, 32'hF);
        expect_at(T + 10, "C_auto_rst0", 1, 32'hE);
        expect_at(T + 15, "C_auto_en2", 0, 32'h5);
        expect_at(T + 24, "C_auto_irq", 2, 32'd1);
        wdt_req = 1'b1;
        @(posedge clk); #1;
        wdt_req = 1'b0;
        drain(60);
        apb_wr(4'd0, 32'h4);

        // D: lock loss during CH_RST(2)
        apb_wr(4'd0, 32'h0);
        T = cyc + 1;
        expect_at(T + 1, "D_swrst_rst", 1, 32'hF);
        expect_at(T + 4, "D_swrst_en_hold", 0, 32'h5);
        expect_at(T + 5, "D_swrst_en_off", 0, 32'h0);
        apb_wr(4'd0, 32'h2);
        drain(20);
        apb_wr(4'd1, 32'hF);
        apb_wr(4'd2, 32'd2);
        T = cyc + 1;
        expect_at(T + 1, "D_en0_lock", 0, 32'h1);
        expect_at(T + 11, "D_rst_chrst2", 1, 32'h8);
        expect_at(T + 12, "D_lockloss_rst", 1, 32'hF);
        expect_at(T + 13, "D_en_hold", 0, 32'h7);
        expect_at(T + 14, "D_en_off", 0, 32'h0);
        apb_wr(4'd0, 32'h1);
        wait_cyc(T + 11);
        pll_lock = 1'b0;
        drain(20);
        apb_rd(4'd4, v); check_eq("D_stat_idle", v, 32'h0);

        // E: lock timeout, START ignored in ERR, SWRST, TERR clear
        apb_wr(4'd3, 32'd10);
        T = cyc + 1;
        expect_at(T + 10, "E_irq_pre", 2, 32'd0);
        expect_at(T + 11, "E_irq", 2, 32'd1);
        expect_at(T + 12, "E_irq_post", 2, 32'd0);
        apb_wr(4'd0, 32'h1);
        drain(30);
        apb_rd(4'd4, v); check_eq("E_stat_err", v, 32'h64);
        apb_wr(4'd0, 32'h1);
        apb_rd(4'd4, v); check_eq("E_start_in_err", v, 32'h64);
        apb_wr(4'd0, 32'h2);
        apb_rd(4'd4, v); check_eq("E_stat_terr_sticky", v, 32'h04);
        apb_wr(4'd4, 32'h4);
        apb_rd(4'd4, v); check_eq("E_stat_terr_clr", v, 32'h0);

        // F: SWRST and START in one write start nothing
        pll_lock = 1'b1;
        T = cyc + 1;
        expect_at(T + 1, "F_en_t1", 0, 32'h0);
        expect_at(T + 3, "F_en_t3", 0, 32'h0);
        apb_wr(4'd0, 32'h3);
        drain(10);
        apb_rd(4'd4, v); check_eq("F_stat_idle", v, 32'h0);

        // G: rst_i mid-sequence
        apb_wr(4'd2, 32'd5);
        T = cyc + 1;
        expect_at(T + 7, "G_en_mid", 0, 32'h1);
        expect_at(T + 7, "G_rst_mid", 1, 32'hE);
        apb_wr(4'd0, 32'h1);
        wait_cyc(T + 8);
        rst = 1'b1;
        #1;
        check_eq("G_clk_en", 32'(clk_en), 32'h0);
        check_eq("G_rst", 32'(rst_v), 32'hF);
        check_eq("G_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        apb_rd(4'd0, v); check_eq("G_rd_ctrl", v, 32'h0);
        apb_rd(4'd2, v); check_eq("G_rd_dly", v, 32'd8);
        apb_rd(4'd3, v); check_eq("G_rd_tmo", v, 32'hFFFF);
        apb_rd(4'd4, v); check_eq("G_rd_stat", v, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
